// File: rtl/sysbus_pkg.sv
// Shared definitions for the system-bus UART transmitter: register offsets,
// transmitter state encoding and STATUS bit positions.
package sysbus_pkg;

  // Word offsets (addr[3:2]) of the UART registers
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_BAUD   = 2'd3;

  // Serialiser states for one 8N1 frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // Bit positions inside the STATUS register
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding bytes waiting to be transmitted. The head entry is
// visible on dout whenever the FIFO is not empty. A push while full is only
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_MAX);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage array: written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sysbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the system bus. Bytes written to
// TXDATA queue in a FIFO and are shifted out LSB first at BAUD clocks per bit.
// Optional feature macro: SYSBUS_UART_IRQ_EN adds the tx_irq output and makes
// CTRL[1] (irq_enable) writable.
module sysbus_uart_tx
  import sysbus_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        system_bus_en,
  input  logic        system_bus_rdwr,
  input  logic [31:0] system_bus_addr,
  input  logic [31:0] system_bus_wr_data,
  input  logic [3:0]  system_bus_mask,
  output logic [31:0] system_bus_rd_data,
  output logic        uart_tx
`ifdef SYSBUS_UART_IRQ_EN
  ,
  output logic        tx_irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e r_state;
  logic [15:0]    r_baud;
  logic [15:0]    r_div;
  logic [15:0]    r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_tx_enable;
  logic           r_overflow;
  logic [31:0]    r_rd_data;

  logic [1:0]     w_offset;
  logic           w_wr;
  logic           w_rd;
  logic           w_push_req;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_busy;
  logic           w_bit_end;
  logic           w_irq_enable;
  logic [7:0]     w_fifo_dout;
  logic [CW-1:0]  w_count;
  logic [31:0]    w_rd_value;
  logic           w_unused;

  assign w_offset   = system_bus_addr[3:2];
  assign w_wr       = system_bus_en && system_bus_rdwr;
  assign w_rd       = system_bus_en && !system_bus_rdwr;
  assign w_push_req = w_wr && (w_offset == UART_TXDATA) && system_bus_mask[0];
  assign w_pop      = (r_state == IDLE) && r_tx_enable && !w_empty;
  assign w_busy     = (r_state != IDLE);
  assign w_bit_end  = (r_cnt == r_div - 16'd1);
  assign w_unused   = ^{system_bus_addr[31:4], system_bus_addr[1:0],
                        system_bus_wr_data[31:16], system_bus_mask[3:2]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (system_bus_wr_data[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

`ifdef SYSBUS_UART_IRQ_EN
  logic r_irq_enable;
  logic r_irq;

  assign w_irq_enable = r_irq_enable;
  assign tx_irq       = r_irq;

  // Interrupt flags "everything sent": FIFO drained and serialiser idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_enable <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_wr && (w_offset == UART_CTRL) && system_bus_mask[0])
        r_irq_enable <= system_bus_wr_data[1];
      r_irq <= r_irq_enable && w_empty && !w_busy;
    end
  end
`else
  assign w_irq_enable = 1'b0;
`endif

  // Register writes; a dropped push (full FIFO, no pop) sets the sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_enable <= 1'b0;
      r_baud      <= DEFAULT_DIV;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_req && w_full && !w_pop)
        r_overflow <= 1'b1;
      else if (w_wr && (w_offset == UART_STATUS) && system_bus_wr_data[STAT_OVERFLOW])
        r_overflow <= 1'b0;
      if (w_wr && (w_offset == UART_CTRL) && system_bus_mask[0])
        r_tx_enable <= system_bus_wr_data[0];
      if (w_wr && (w_offset == UART_BAUD)) begin
        if (system_bus_mask[0]) r_baud[7:0]  <= system_bus_wr_data[7:0];
        if (system_bus_mask[1]) r_baud[15:8] <= system_bus_wr_data[15:8];
      end
    end
  end

  // Read-data mux for the addressed register
  always_comb begin
    w_rd_value = '0;
    case (w_offset)
      UART_STATUS: begin
        w_rd_value[STAT_FULL]                     = w_full;
        w_rd_value[STAT_EMPTY]                    = w_empty;
        w_rd_value[STAT_BUSY]                     = w_busy;
        w_rd_value[STAT_OVERFLOW]                 = r_overflow;
        w_rd_value[STAT_COUNT_LSB+7:STAT_COUNT_LSB] = 8'(w_count);
      end
      UART_CTRL: begin
        w_rd_value[0] = r_tx_enable;
        w_rd_value[1] = w_irq_enable;
      end
      UART_BAUD: w_rd_value[15:0] = r_baud;
      default:   w_rd_value = '0;
    endcase
  end

  // Read data is captured only on a read access and held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_data <= '0;
    else if (w_rd) r_rd_data <= w_rd_value;
  end

  assign system_bus_rd_data = r_rd_data;

  // Frame serialiser; the divisor is frozen at frame start so BAUD writes
  // mid-frame only affect the next frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_div   <= 16'd1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_div   <= (r_baud == 16'd0) ? 16'd1 : r_baud;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line level follows the state; reset forces IDLE and therefore a high line
  always_comb begin
    case (r_state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = r_shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sysbus_uart_tx.sv
// Directed testbench for sysbus_uart_tx: reset values, single frame timing,
// FIFO overflow, back-to-back frames, mid-frame async reset and the interrupt
// (or its absence, depending on SYSBUS_UART_IRQ_EN).
module tb_sysbus_uart_tx;

  logic        clk;
  logic        rst;
  logic        busEn;
  logic        busRdwr;
  logic [31:0] busAddr;
  logic [31:0] busWrData;
  logic [3:0]  busMask;
  logic [31:0] busRdData;
  logic        uartTx;
`ifdef SYSBUS_UART_IRQ_EN
  logic        txIrq;
`endif

  int checkCount = 0;
  int passCount  = 0;

  sysbus_uart_tx #(
    .FIFO_DEPTH  (16),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .system_bus_en      (busEn),
    .system_bus_rdwr    (busRdwr),
    .system_bus_addr    (busAddr),
    .system_bus_wr_data (busWrData),
    .system_bus_mask    (busMask),
    .system_bus_rd_data (busRdData),
    .uart_tx            (uartTx)
`ifdef SYSBUS_UART_IRQ_EN
    ,
    .tx_irq             (txIrq)
`endif
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for one bit slot of an 8N1 frame: 0 start, 1..8 data, 9 stop
  function automatic logic expBit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot >= 1 && slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  // One-cycle write strobe; takes effect on the posedge in the middle
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    busEn = 1'b1; busRdwr = 1'b1; busAddr = a; busWrData = d; busMask = m;
    @(negedge clk);
    busEn = 1'b0; busRdwr = 1'b0; busMask = 4'h0;
  endtask

  // One-cycle read strobe; rd_data is sampled one edge later
  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    busEn = 1'b1; busRdwr = 1'b0; busAddr = a;
    @(negedge clk);
    busEn = 1'b0;
    d = busRdData;
  endtask

  // Wait (bounded) for the line to drop at a negedge sample
  task automatic waitTxLow(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (uartTx === 1'b0) found = 1'b1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    busRead(32'h4, d);
    checkCount++;
    if (d !== 32'h0000_0002) $display("[TB] FAIL reset_status: got %h expected %h", d, 32'h2);
    else passCount++;
    busRead(32'hC, d);
    checkCount++;
    if (d !== 32'd868) $display("[TB] FAIL reset_baud: got %0d expected 868", d);
    else passCount++;
    checkCount++;
    if (uartTx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", uartTx);
    else passCount++;
  endtask

  task automatic test_single_frame();
    logic        samples [40];
    logic [7:0]  b;
    logic [31:0] d;
    bit          found;
    int          bad;
    b = 8'hA5;
    busWrite(32'hC, 32'd4, 4'hF);
    busWrite(32'h8, 32'd1, 4'hF);
    busWrite(32'h0, {24'h0, b}, 4'h1);
    waitTxLow(found);
    checkCount++;
    if (!found) begin
      $display("[TB] FAIL frame_start: got no start bit expected start within 200 cycles");
      return;
    end
    passCount++;
    samples[0] = uartTx;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      samples[k] = uartTx;
    end
    for (int s = 0; s < 10; s++) begin
      bad = 0;
      for (int c = 0; c < 4; c++)
        if (samples[s*4+c] !== expBit(b, s)) bad++;
      checkCount++;
      if (bad != 0)
        $display("[TB] FAIL frame_slot%0d: got %b%b%b%b expected 4 x %b", s,
                 samples[s*4], samples[s*4+1], samples[s*4+2], samples[s*4+3], expBit(b, s));
      else passCount++;
    end
    busRead(32'h4, d);
    checkCount++;
    if (d !== 32'h0000_0002) $display("[TB] FAIL frame_done_status: got %h expected %h", d, 32'h2);
    else passCount++;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    busWrite(32'h8, 32'd0, 4'hF);
    for (int i = 0; i < 17; i++)
      busWrite(32'h0, 32'h10 + i, 4'h1);
    busRead(32'h4, d);
    checkCount++;
    if (d !== 32'h0000_1009) $display("[TB] FAIL overflow_status: got %h expected %h", d, 32'h1009);
    else passCount++;
    busWrite(32'h4, 32'h8, 4'hF);
    busRead(32'h4, d);
    checkCount++;
    if (d !== 32'h0000_1001) $display("[TB] FAIL overflow_clear: got %h expected %h", d, 32'h1001);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic        samples [62];
    logic [7:0]  bytes [3];
    logic [31:0] d;
    bit          found;
    int          bad;
    logic        e;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    busWrite(32'hC, 32'd2, 4'h3);
    for (int i = 0; i < 3; i++) busWrite(32'h0, {24'h0, bytes[i]}, 4'h1);
    busWrite(32'h8, 32'd1, 4'hF);
    waitTxLow(found);
    checkCount++;
    if (!found) begin
      $display("[TB] FAIL b2b_start: got no start bit expected start within 200 cycles");
      return;
    end
    passCount++;
    samples[0] = uartTx;
    for (int k = 1; k < 62; k++) begin
      @(negedge clk);
      samples[k] = uartTx;
    end
    for (int f = 0; f < 3; f++) begin
      bad = 0;
      for (int p = 0; p < 21; p++) begin
        if (f*21 + p < 62) begin
          e = (p == 20) ? 1'b1 : expBit(bytes[f], p / 2);
          if (samples[f*21+p] !== e) bad++;
        end
      end
      checkCount++;
      if (bad != 0) $display("[TB] FAIL b2b_frame%0d: got %0d wrong cycles expected 0", f, bad);
      else passCount++;
    end
    busRead(32'h4, d);
    checkCount++;
    if (d !== 32'h0000_0002) $display("[TB] FAIL b2b_end_status: got %h expected %h", d, 32'h2);
    else passCount++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bit          found;
    busWrite(32'hC, 32'd4, 4'h3);
    busWrite(32'h0, 32'hA5, 4'h1);
    busWrite(32'h0, 32'h11, 4'h1);
    waitTxLow(found);
    checkCount++;
    if (!found) begin
      $display("[TB] FAIL arst_start: got no start bit expected start within 200 cycles");
      return;
    end
    passCount++;
    repeat (17) @(negedge clk);
    checkCount++;
    if (uartTx !== 1'b0) $display("[TB] FAIL arst_bit3: got %b expected 0", uartTx);
    else passCount++;
    rst = 1'b0;
    #1;
    checkCount++;
    if (uartTx !== 1'b1) $display("[TB] FAIL arst_tx_high: got %b expected 1", uartTx);
    else passCount++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    busRead(32'h4, d);
    checkCount++;
    if (d !== 32'h0000_0002) $display("[TB] FAIL arst_status: got %h expected %h", d, 32'h2);
    else passCount++;
    busRead(32'h8, d);
    checkCount++;
    if (d !== 32'h0) $display("[TB] FAIL arst_ctrl: got %h expected 0", d);
    else passCount++;
    busRead(32'hC, d);
    checkCount++;
    if (d !== 32'd868) $display("[TB] FAIL arst_baud: got %0d expected 868", d);
    else passCount++;
  endtask

  task automatic test_irq();
    logic [31:0] d;
`ifdef SYSBUS_UART_IRQ_EN
    bit found;
    int bad;
    busWrite(32'hC, 32'd2, 4'h3);
    busWrite(32'h8, 32'd0, 4'hF);
    busWrite(32'h0, 32'h55, 4'h1);
    checkCount++;
    if (txIrq !== 1'b0) $display("[TB] FAIL irq_before: got %b expected 0", txIrq);
    else passCount++;
    busWrite(32'h8, 32'd3, 4'hF);
    waitTxLow(found);
    checkCount++;
    if (!found) begin
      $display("[TB] FAIL irq_start: got no start bit expected start within 200 cycles");
      return;
    end
    passCount++;
    bad = (txIrq !== 1'b0) ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (txIrq !== 1'b0) bad++;
    end
    checkCount++;
    if (bad != 0) $display("[TB] FAIL irq_during: got %0d high cycles expected 0", bad);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (txIrq !== 1'b1) $display("[TB] FAIL irq_after: got %b expected 1", txIrq);
    else passCount++;
    busRead(32'h8, d);
    checkCount++;
    if (d !== 32'h3) $display("[TB] FAIL irq_ctrl_read: got %h expected 3", d);
    else passCount++;
`else
    busWrite(32'h8, 32'd3, 4'hF);
    busRead(32'h8, d);
    checkCount++;
    if (d !== 32'h1) $display("[TB] FAIL ctrl_no_irq: got %h expected 1", d);
    else passCount++;
`endif
  endtask

  // Test sequence
  initial begin
    rst = 1'b0; busEn = 1'b0; busRdwr = 1'b0;
    busAddr = '0; busWrData = '0; busMask = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_single_frame();
    test_overflow();
    doReset();
    test_back_to_back();
    test_async_reset();
    test_irq();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
